mem_arbiter: RTL

Two-requester arbiter and sequencer for a single-port synchronous SRAM (`mem_wrapper`, write-first-priority, 1-cycle registered read). It accepts independent valid/ready read/write requests from two clients, grants at most one per cycle onto the SRAM port, and returns read data to the originating client with fixed latency. It sits between datapath clients (e.g. buffer loaders/drainers) and one `mem_wrapper` instance.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-client arbiter/sequencer for a single-port SRAM with 1-cycle registered read.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority to client 0.

module mem_arb_rsp_lane #(
   parameter int   DATA_WIDTH = 16,
   parameter logic ID         = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s1_vld,
   input  logic                  s1_id,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata
);
   logic hit;

   assign hit = s1_vld && (s1_id == ID);

   // rdata is held between responses so a client may sample it late
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= hit;
         if (hit) rsp_rdata <= mem_dout;
      end
   end
endmodule

module mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);
   localparam int NUM_CLIENTS = 2;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   req_t [NUM_CLIENTS-1:0]                  req;
   logic [NUM_CLIENTS-1:0]                  valid;
   logic [NUM_CLIENTS-1:0]                  gnt;
   logic                                    sel;
   logic                                    last_gnt;
   logic                                    s1_vld;
   logic                                    s1_id;
   logic [NUM_CLIENTS-1:0]                  rsp_valid;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rsp_rdata;

   assign req[0] = {req0_we, req0_addr, req0_wdata};
   assign req[1] = {req1_we, req1_addr, req1_wdata};
   assign valid  = {req1_valid, req0_valid};

   // grant is gated by rst_n so no handshake can complete while in reset
   always_comb begin
      gnt = '0;
      if (rst_n) begin
         if (&valid) begin
`ifdef MEM_ARB_RR_EN
            if (last_gnt) gnt[0] = 1'b1;
            else          gnt[1] = 1'b1;
`else
            gnt[0] = 1'b1;
`endif
         end else begin
            gnt = valid;
         end
      end
   end

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   // ungranted cycles leave the client-0 address/data on the port
   assign sel      = gnt[1];
   assign mem_ce   = |gnt;
   assign mem_we   = mem_ce & req[sel].we;
   assign mem_addr = req[sel].addr;
   assign mem_din  = req[sel].wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         s1_vld   <= 1'b0;
         s1_id    <= 1'b0;
      end else begin
         last_gnt <= gnt[1] | (last_gnt & ~gnt[0]);
         s1_vld   <= mem_ce & ~mem_we;
         s1_id    <= sel;
      end
   end

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
      mem_arb_rsp_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ID         (1'(i))
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .s1_vld    (s1_vld),
         .s1_id     (s1_id),
         .mem_dout  (mem_dout),
         .rsp_valid (rsp_valid[i]),
         .rsp_rdata (rsp_rdata[i])
      );
   end

   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_rdata = rsp_rdata[0];
   assign rsp1_rdata = rsp_rdata[1];
endmodule
